// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters.
// Define ALU_SHARE_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              busy
);

  localparam int CNT_W = $clog2(MUL_LAT + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic              grant;
  logic              owner;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [2:0]        alu_ctrl_q;

  logic              accept;
  logic              rsp_fire;
  logic              op_ok;
  logic [2:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  always_comb begin
    grant = 1'b0;
    if (!req0_valid && req1_valid)
      grant = 1'b1;
  end
`else
  logic ptr;

  // With no contention the lone requester wins; otherwise the pointer decides.
  always_comb begin
    grant = ptr;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (!req0_valid && req1_valid)
      grant = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (rsp_fire)
      ptr <= ~owner;
  end
`endif

  always_comb begin
    sel_op = grant ? req1_op : req0_op;
    sel_a  = grant ? req1_a  : req0_a;
    sel_b  = grant ? req1_b  : req0_b;
    op_ok  = (sel_op != 3'b011) && (sel_op != 3'b111);
    accept = (state == IDLE) && (grant ? req1_valid : req0_valid);
    rsp_fire = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = op_ok ? EXEC : RESP;
      EXEC: if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP: if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Unsupported opcodes never reach the ALU drive registers, so the ALU sees no new op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      cnt        <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= grant;
            if (op_ok) begin
              alu_a_q    <= sel_a;
              alu_b_q    <= sel_b;
              alu_ctrl_q <= sel_op;
              cnt        <= (sel_op == 3'b101) ? CNT_W'(MUL_LAT) : CNT_W'(1);
            end else begin
              rsp_data_q <= '0;
              rsp_zero_q <= 1'b0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_data_q <= alu_out;
            rsp_zero_q <= alu_zero;
            rsp_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req0_ready = (state == IDLE) && !grant;
    req1_ready = (state == IDLE) &&  grant;
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) &&  owner;
    rsp0_data  = rsp_data_q;
    rsp1_data  = rsp_data_q;
    rsp0_zero  = rsp_zero_q;
    rsp1_zero  = rsp_zero_q;
    rsp0_err   = rsp_err_q;
    rsp1_err   = rsp_err_q;
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_ctrl   = alu_ctrl_q;
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter against a transaction-level model.
// Honours ALU_SHARE_FIXED_PRIO_EN for the expected grant order.
module tb_alu_share_arbiter;

  localparam int DATA_W  = 32;
  localparam int MUL_LAT = 2;
`ifdef ALU_SHARE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [2:0]        req0_op, req1_op;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp0_data, rsp1_data;
  logic              rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]        alu_ctrl;
  logic              alu_zero;
  logic              busy;

  int checks = 0;
  int errors = 0;

  int                ptr_model = 0;
  logic [2:0]        last_ctrl = 3'b000;
  logic [2:0]        op_s [2];
  logic [DATA_W-1:0] a_s  [2];
  logic [DATA_W-1:0] b_s  [2];

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_zero(alu_zero),
    .busy(busy)
  );

  function automatic logic [DATA_W-1:0] aluFunc(input logic [2:0] op, input logic [DATA_W-1:0] a, b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  // Stand-in for the shared combinational ALU.
  always_comb begin
    alu_out  = aluFunc(alu_ctrl, alu_a, alu_b);
    alu_zero = (alu_out == '0);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One arbitrated transaction: raise valids, check grant, latency, result, then backpressure and consume.
  task automatic applyStimulus(input bit v0, input bit v1, input int hold);
    int g, exp_g, exp_lat, lat, waited;
    bit ok;
    logic [DATA_W-1:0] exp_data, held_data;
    logic held_zero, held_err;
    @(negedge clk);
    req0_valid = v0; req0_op = op_s[0]; req0_a = a_s[0]; req0_b = b_s[0];
    req1_valid = v1; req1_op = op_s[1]; req1_a = a_s[1]; req1_b = b_s[1];
    #1;
    exp_g = (v0 && v1) ? (FIXED ? 0 : ptr_model) : (v0 ? 0 : 1);
    waited = 0;
    while (!(req0_valid && req0_ready) && !(req1_valid && req1_ready) && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    checkOutput("accept_in_time", 64'(waited < 20), 64'(1));
    g = (req1_valid && req1_ready) ? 1 : 0;
    checkOutput("grant", 64'(g), 64'(exp_g));
    ok = (op_s[g] != 3'b011) && (op_s[g] != 3'b111);
    exp_data = ok ? aluFunc(op_s[g], a_s[g], b_s[g]) : '0;
    exp_lat  = !ok ? 1 : ((op_s[g] == 3'b101) ? 1 + MUL_LAT : 2);
    @(posedge clk); #1;
    if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    lat = 1;
    while (!(g ? rsp1_valid : rsp0_valid) && lat < 20) begin
      checkOutput("exec_ctrl", 64'(alu_ctrl), 64'(op_s[g]));
      checkOutput("exec_a", 64'(alu_a), 64'(a_s[g]));
      checkOutput("exec_b", 64'(alu_b), 64'(b_s[g]));
      checkOutput("exec_no_ready", 64'({req0_ready, req1_ready}), 64'(0));
      @(posedge clk); #1; lat++;
    end
    checkOutput("latency", 64'(lat), 64'(exp_lat));
    checkOutput("rsp_data", 64'(g ? rsp1_data : rsp0_data), 64'(exp_data));
    checkOutput("rsp_zero", 64'(g ? rsp1_zero : rsp0_zero), 64'(ok && exp_data == '0));
    checkOutput("rsp_err", 64'(g ? rsp1_err : rsp0_err), 64'(!ok));
    checkOutput("other_rsp_idle", 64'(g ? rsp0_valid : rsp1_valid), 64'(0));
    if (!ok) checkOutput("unsup_ctrl_kept", 64'(alu_ctrl), 64'(last_ctrl));
    held_data = g ? rsp1_data : rsp0_data;
    held_zero = g ? rsp1_zero : rsp0_zero;
    held_err  = g ? rsp1_err  : rsp0_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 64'(g ? rsp1_valid : rsp0_valid), 64'(1));
      checkOutput("hold_stable", 64'({held_data, held_zero, held_err}),
                  64'({(g ? rsp1_data : rsp0_data), (g ? rsp1_zero : rsp0_zero), (g ? rsp1_err : rsp0_err)}));
      checkOutput("hold_no_ready", 64'({req0_ready, req1_ready}), 64'(0));
    end
    if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    checkOutput("done_idle", 64'({busy, rsp0_valid, rsp1_valid}), 64'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    ptr_model = 1 - g;
    if (ok) last_ctrl = op_s[g];
  endtask

  function automatic logic [DATA_W-1:0] randOperand();
    return ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
  endfunction

  initial begin
    int v;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    for (int i = 0; i < 2; i++) begin op_s[i] = 0; a_s[i] = 0; b_s[i] = 0; end
    #13;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    checkOutput("reset_rsp_flags", 64'({rsp0_zero, rsp0_err, rsp1_zero, rsp1_err}), 64'(0));
    checkOutput("reset_rsp_data", 64'(rsp0_data | rsp1_data), 64'(0));
    checkOutput("reset_alu", 64'({alu_a, alu_ctrl}), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    op_s[0] = 3'b010; a_s[0] = 5; b_s[0] = 7;
    applyStimulus(1, 0, 0);
    op_s[1] = 3'b100; a_s[1] = 9; b_s[1] = 9;
    applyStimulus(0, 1, 0);
    op_s[0] = 3'b101; a_s[0] = 6; b_s[0] = 7;
    applyStimulus(1, 0, 0);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 2; i++) begin
        op_s[i] = 3'($urandom_range(0, 7)); a_s[i] = randOperand(); b_s[i] = randOperand();
      end
      applyStimulus(1, 1, 0);
    end

    op_s[1] = 3'b111; a_s[1] = 32'h1234; b_s[1] = 32'h5678;
    applyStimulus(0, 1, 5);

    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 2; i++) begin
        op_s[i] = 3'($urandom_range(0, 7)); a_s[i] = randOperand(); b_s[i] = randOperand();
      end
      v = $urandom_range(1, 3);
      applyStimulus(v[0], v[1], $urandom_range(0, 2));
    end

    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'b101; req0_a = 3; req0_b = 4;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checkOutput("mul_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    checkOutput("rst_alu", 64'({alu_a, alu_b, alu_ctrl}), 64'(0));
    checkOutput("rst_rsp_data", 64'(rsp0_data), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    ptr_model = 0; last_ctrl = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("no_stale_rsp", 64'({busy, rsp0_valid, rsp1_valid}), 64'(0));
    end
    op_s[1] = 3'b001; a_s[1] = 32'hF0; b_s[1] = 32'h0F;
    applyStimulus(0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
